// File: rtl/arp_pkg.sv
// arp_pkg: shared FSM states and frame layout constants for the ARP transmitter
package arp_pkg;
   typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, PAD, FCS, IFG} arp_state_t;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
   localparam logic [7:0]  ARP_HLEN      = 8'd6;
   localparam logic [7:0]  ARP_PLEN      = 8'd4;
   localparam logic [15:0] ARP_OP_REQ    = 16'd1;
   localparam logic [15:0] ARP_OP_REPLY  = 16'd2;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [6:0]  PREAMBLE_LEN  = 7'd8;
   localparam logic [6:0]  ETH_HEAD_LEN  = 7'd14;
   localparam logic [6:0]  ARP_DATA_LEN  = 7'd28;
   localparam logic [6:0]  PAD_LEN       = 7'd18;
   localparam logic [6:0]  FCS_LEN       = 7'd4;
   localparam logic [6:0]  IFG_CYCLES    = 7'd12;
   // last byte_cnt value of each section, counted across the whole frame
   localparam logic [6:0]  PRE_END   = PREAMBLE_LEN - 7'd1;
   localparam logic [6:0]  HEAD_END  = PRE_END + ETH_HEAD_LEN;
   localparam logic [6:0]  ARP_END   = HEAD_END + ARP_DATA_LEN;
   localparam logic [6:0]  PAD_END   = ARP_END + PAD_LEN;
   localparam logic [6:0]  FCS_END   = PAD_END + FCS_LEN;
   localparam logic [6:0]  IFG_END   = IFG_CYCLES - 7'd1;
   localparam logic [6:0]  FCS_FIRST = PAD_END + 7'd1;
   localparam logic [6:0]  CRC_FIRST = PREAMBLE_LEN + 7'd1;
endpackage

// File: rtl/arp_tx_crc32_d8.sv
// crc32_d8: byte-wide reflected IEEE 802.3 CRC-32 with registered and look-ahead outputs
module crc32_d8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_in,
   input  logic        crc_en,
   input  logic        crc_clr,
   output logic [31:0] crc_data,
   output logic [31:0] crc_next
);
   localparam logic [31:0] POLY_REFL = 32'hEDB88320;
   always_comb begin
      crc_next = crc_data ^ {24'd0, data_in};
      for (int i = 0; i < 8; i++)
         crc_next = crc_next[0] ? (crc_next >> 1) ^ POLY_REFL : crc_next >> 1;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc_data <= '1;
      else if (crc_clr) crc_data <= '1;
      else if (crc_en) crc_data <= crc_next;
endmodule

// File: rtl/arp_tx.sv
// arp_tx: builds and streams Ethernet II ARP request/reply frames with FCS and IFG
module arp_tx
   import arp_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC_ADDR = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP_ADDR  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
   input  logic        eth_txc,
   input  logic        rst,
   input  logic        arp_tx_en,
   input  logic        arp_tx_type,
   input  logic [47:0] dest_mac_addr,
   input  logic [31:0] dest_ip_addr,
   output logic [7:0]  tx_databyte,
   output logic        tx_databyte_en,
   output logic        arp_busy,
   output logic        tx_done
);
   arp_state_t state, state_nx;
   logic [6:0]   byte_cnt, cnt_nx;
   logic         type_r;
   logic [47:0]  mac_r, eth_dst, tgt_mac;
   logic [31:0]  ip_r, crc_data, crc_next;
   logic [15:0]  opcode;
   logic [543:0] hdr;
   logic [9:0]   bit_base;
   logic [7:0]   byte_nx;
   logic         in_frame, crc_en, crc_clr;

   assign eth_dst  = type_r ? mac_r : {48{1'b1}};
   assign tgt_mac  = type_r ? mac_r : 48'd0;
   assign opcode   = type_r ? ARP_OP_REPLY : ARP_OP_REQ;
   // bytes 0..67 as one MSB-first vector; the FCS bytes are appended separately
   assign hdr = {{7{PREAMBLE_BYTE}}, SFD_BYTE, eth_dst, BOARD_MAC_ADDR, ETH_TYPE_ARP,
                 ARP_HTYPE_ETH, ARP_PTYPE_IP, ARP_HLEN, ARP_PLEN, opcode,
                 BOARD_MAC_ADDR, BOARD_IP_ADDR, tgt_mac, ip_r, 144'd0};
   assign bit_base = {PAD_END - byte_cnt, 3'b000};
   assign in_frame = state inside {PREAMBLE, ETH_HEAD, ARP_DATA, PAD, FCS};
   // CRC consumes the registered output byte, so enable lags the counter by one
   assign crc_en   = in_frame && byte_cnt >= CRC_FIRST && byte_cnt <= FCS_FIRST;
   assign crc_clr  = state == PREAMBLE;
   assign byte_nx  = byte_cnt <= PAD_END ? hdr[bit_base +: 8] :
                     byte_cnt == FCS_FIRST ? ~crc_next[7:0] :
                     byte_cnt == FCS_FIRST + 7'd1 ? ~crc_data[15:8] :
                     byte_cnt == FCS_FIRST + 7'd2 ? ~crc_data[23:16] : ~crc_data[31:24];

   always_comb begin
      state_nx = state;
      cnt_nx   = byte_cnt + 7'd1;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (arp_tx_en) state_nx = PREAMBLE;
         end
         PREAMBLE: if (byte_cnt == PRE_END) state_nx = ETH_HEAD;
         ETH_HEAD: if (byte_cnt == HEAD_END) state_nx = ARP_DATA;
         ARP_DATA: if (byte_cnt == ARP_END) state_nx = PAD;
         PAD:      if (byte_cnt == PAD_END) state_nx = FCS;
         FCS: if (byte_cnt == FCS_END) begin
            state_nx = IFG;
            cnt_nx   = '0;
         end
         IFG: if (byte_cnt == IFG_END) begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge eth_txc or posedge rst)
      if (rst) begin
         state          <= IDLE;
         byte_cnt       <= '0;
         type_r         <= 1'b0;
         mac_r          <= '0;
         ip_r           <= '0;
         tx_databyte    <= '0;
         tx_databyte_en <= 1'b0;
         arp_busy       <= 1'b0;
         tx_done        <= 1'b0;
      end else begin
         state          <= state_nx;
         byte_cnt       <= cnt_nx;
         if (state == IDLE && arp_tx_en) begin
            type_r <= arp_tx_type;
            mac_r  <= dest_mac_addr;
            ip_r   <= dest_ip_addr;
         end
         tx_databyte    <= in_frame ? byte_nx : 8'h00;
         tx_databyte_en <= in_frame;
         arp_busy       <= state != IDLE;
         tx_done        <= state == IFG && byte_cnt == '0;
      end

   crc32_d8 u_crc (
      .clk      (eth_txc),
      .rst_n    (~rst),
      .data_in  (tx_databyte),
      .crc_en   (crc_en),
      .crc_clr  (crc_clr),
      .crc_data (crc_data),
      .crc_next (crc_next)
   );
endmodule
